// File: rtl/clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_gen
// Purpose  : Multi-channel fractional clock-enable generator. Each channel is
//            a phase accumulator (NCO) whose carry-out becomes a one-cycle
//            enable strobe and toggles a square-wave output. Increments are
//            written into shadow registers and committed atomically by an
//            apply strobe, which also phase-aligns all channels and restarts
//            a lock countdown that gates the outputs.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC =
        {32'h51EB851E, 32'h40000000, 32'h28F5C28F, 32'h80000000},
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              cfg_apply,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    // Lock counter only needs to reach LOCK_CYCLES-1.
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } lock_state_t;

    lock_state_t      state;
    lock_state_t      state_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_nxt;

    // Lock state register, countdown and registered locked flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAIT;
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            locked   <= (state_nxt == ST_RUN);
        end
    end

    // Next-state logic: count up in WAIT, enter RUN on the last count; apply
    // always wins and restarts the countdown from zero.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        case (state)
            ST_WAIT: begin
                if (lock_cnt == CNT_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    lock_cnt_nxt = lock_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt    = ST_WAIT;
                lock_cnt_nxt = '0;
            end
        endcase
        if (cfg_apply) begin
            state_nxt    = ST_WAIT;
            lock_cnt_nxt = '0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [ACC_W-1:0] shadow;
        logic [ACC_W-1:0] active;
        logic [ACC_W-1:0] acc;
        logic [ACC_W:0]   sum;
        logic             ce_r;
        logic             clk_r;
        logic             wr_hit;

        // Out-of-range channel indices never match any channel, so such
        // writes fall away without extra decoding.
        assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));
        assign sum    = {1'b0, acc} + {1'b0, active};

        // Shadow/active increments; apply copies shadow to active, with the
        // same-edge write value bypassed straight through.
        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                shadow <= DEFAULT_INC[i*ACC_W +: ACC_W];
                active <= DEFAULT_INC[i*ACC_W +: ACC_W];
            end else begin
                if (wr_hit) begin
                    shadow <= cfg_inc;
                end
                if (cfg_apply) begin
                    active <= wr_hit ? cfg_inc : shadow;
                end
            end
        end

        // Phase accumulator: carry out becomes the registered strobe and
        // toggles the square wave; held at zero until locked.
        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                acc   <= '0;
                ce_r  <= 1'b0;
                clk_r <= 1'b0;
            end else if (cfg_apply || state != ST_RUN) begin
                acc   <= '0;
                ce_r  <= 1'b0;
                clk_r <= 1'b0;
            end else begin
                acc  <= sum[ACC_W-1:0];
                ce_r <= sum[ACC_W];
                if (sum[ACC_W]) begin
                    clk_r <= ~clk_r;
                end
            end
        end

        assign ce[i]      = ce_r;
        assign clk_out[i] = clk_r;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_en_gen
// Purpose  : Directed self-checking bench for clk_en_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_en_gen;

    localparam int LOCK = 16;
    localparam logic [127:0] DEF =
        {32'h51EB851E, 32'h40000000, 32'h28F5C28F, 32'h80000000};

    logic        refclk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_inc;
    logic        cfg_apply;
    logic [3:0]  ce;
    logic [3:0]  clk_out;
    logic        locked;

    logic        cfg3_we;
    logic [1:0]  cfg3_ch;
    logic [31:0] cfg3_inc;
    logic        cfg3_apply;
    logic [2:0]  ce3;
    logic [2:0]  clk3;
    logic        locked3;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] cur_inc [4];

    clk_en_gen #(
        .NUM_CH(4), .ACC_W(32), .LOCK_CYCLES(LOCK), .DEFAULT_INC(DEF)
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_apply(cfg_apply), .ce(ce),
        .clk_out(clk_out), .locked(locked)
    );

    // Three-channel instance: index 3 is representable but out of range.
    clk_en_gen #(
        .NUM_CH(3), .ACC_W(32), .LOCK_CYCLES(2),
        .DEFAULT_INC({3{32'h40000000}})
    ) dut3 (
        .refclk(refclk), .rst_n(rst_n), .cfg_we(cfg3_we), .cfg_ch(cfg3_ch),
        .cfg_inc(cfg3_inc), .cfg_apply(cfg3_apply), .ce(ce3),
        .clk_out(clk3), .locked(locked3)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Carry expected on RUN edge r: floor(r*inc/2^32) steps up.
    function automatic logic exp_carry(input logic [31:0] inc, input int r);
        logic [63:0] a;
        logic [63:0] b;
        a = (64'(r) * 64'(inc)) >> 32;
        b = (64'(r - 1) * 64'(inc)) >> 32;
        return a != b;
    endfunction

    function automatic logic [3:0] exp_vec(input int r);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = exp_carry(cur_inc[c], r);
        return v;
    endfunction

    task automatic apply_pulse();
        cfg_apply = 1'b1;
        tick();
        cfg_apply = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_we = 0; cfg_ch = 0; cfg_inc = 0; cfg_apply = 0;
        cfg3_we = 0; cfg3_ch = 0; cfg3_inc = 0; cfg3_apply = 0;
        for (int c = 0; c < 4; c++) cur_inc[c] = DEF[c*32 +: 32];
        repeat (3) tick();
        n_checks++;
        if ({locked, ce, clk_out} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected 000000000", {locked, ce, clk_out});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= LOCK; k++) begin
            tick();
            n_checks++;
            if (locked !== 1'(k == LOCK)) begin
                n_fail++;
                $display("FAIL reset_lock edge %0d: locked=%b expected %b", k, locked, k == LOCK);
            end
            n_checks++;
            if (ce !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_ce_idle edge %0d: ce=%b expected 0000", k, ce);
            end
        end
        for (int r = 1; r <= 12; r++) begin
            tick();
            n_checks++;
            if (ce[2] !== 1'(r % 4 == 0) || ce[0] !== 1'(r % 2 == 0)) begin
                n_fail++;
                $display("FAIL reset_pow2 run %0d: ce2=%b ce0=%b expected %b %b",
                         r, ce[2], ce[0], r % 4 == 0, r % 2 == 0);
            end
            n_checks++;
            if (ce !== exp_vec(r)) begin
                n_fail++;
                $display("FAIL reset_ce run %0d: ce=%b expected %b", r, ce, exp_vec(r));
            end
        end
    endtask

    task automatic test_long_run();
        int cnt [4];
        int clk_bad;
        apply_pulse();
        repeat (LOCK) tick();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL long_lock: locked=%b expected 1", locked);
        end
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        clk_bad = 0;
        for (int r = 1; r <= 10000; r++) begin
            tick();
            for (int c = 0; c < 4; c++) cnt[c] += int'(ce[c]);
            if (clk_out[2] !== 1'((r / 4) % 2)) clk_bad++;
        end
        n_checks++;
        if (cnt[0] != 5000 || cnt[1] != 1599 || cnt[2] != 2500 || cnt[3] != 3199) begin
            n_fail++;
            $display("FAIL long_counts: got %0d %0d %0d %0d expected 5000 1599 2500 3199",
                     cnt[0], cnt[1], cnt[2], cnt[3]);
        end
        n_checks++;
        if (clk_bad != 0) begin
            n_fail++;
            $display("FAIL long_clk2_period8: %0d bad samples expected 0", clk_bad);
        end
    endtask

    task automatic test_write_then_apply();
        int cnt2;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_inc = 32'h20000000;
        tick();
        cfg_we = 1'b0;
        cnt2 = 0;
        repeat (16) begin
            tick();
            cnt2 += int'(ce[2]);
        end
        n_checks++;
        if (cnt2 != 4) begin
            n_fail++;
            $display("FAIL shadow_no_disturb: ch2 pulses=%0d expected 4", cnt2);
        end
        cur_inc[2] = 32'h20000000;
        apply_pulse();
        n_checks++;
        if ({locked, ce, clk_out} !== 9'b0) begin
            n_fail++;
            $display("FAIL apply_clear: got %b expected 000000000", {locked, ce, clk_out});
        end
        for (int k = 1; k <= LOCK; k++) begin
            tick();
            n_checks++;
            if (locked !== 1'(k == LOCK) || ce !== 4'b0) begin
                n_fail++;
                $display("FAIL apply_relock edge %0d: locked=%b ce=%b expected %b 0000",
                         k, locked, ce, k == LOCK);
            end
        end
        for (int r = 1; r <= 24; r++) begin
            tick();
            n_checks++;
            if (ce[2] !== 1'(r % 8 == 0) || ce !== exp_vec(r)) begin
                n_fail++;
                $display("FAIL apply_new_rate run %0d: ce=%b expected %b", r, ce, exp_vec(r));
            end
            if (r == 1) begin
                n_checks++;
                if (clk_out !== 4'b0) begin
                    n_fail++;
                    $display("FAIL apply_align: clk_out=%b expected 0000", clk_out);
                end
            end
        end
    endtask

    task automatic test_same_edge();
        int cnt2;
        int seen1;
        int c3 [3];
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_inc = 32'h0; cfg_apply = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_apply = 1'b0;
        cur_inc[1] = 32'h0;
        repeat (LOCK) tick();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_lock: locked=%b expected 1", locked);
        end
        cnt2 = 0; seen1 = 0;
        for (int r = 1; r <= 48; r++) begin
            tick();
            cnt2 += int'(ce[2]);
            if (ce[1] !== 1'b0 || clk_out[1] !== 1'b0) seen1++;
        end
        n_checks++;
        if (seen1 != 0) begin
            n_fail++;
            $display("FAIL bypass_disable: ch1 active %0d cycles expected 0", seen1);
        end
        n_checks++;
        if (cnt2 != 6) begin
            n_fail++;
            $display("FAIL bypass_ch2_kept: ch2 pulses=%0d expected 6", cnt2);
        end
        // Out-of-range writes on the three-channel instance.
        cfg3_we = 1'b1; cfg3_ch = 2'd3; cfg3_inc = 32'h0;
        tick();
        cfg3_apply = 1'b1;
        tick();
        cfg3_we = 1'b0; cfg3_apply = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (locked3 !== 1'b1) begin
            n_fail++;
            $display("FAIL range_lock: locked3=%b expected 1", locked3);
        end
        for (int c = 0; c < 3; c++) c3[c] = 0;
        repeat (16) begin
            tick();
            for (int c = 0; c < 3; c++) c3[c] += int'(ce3[c]);
        end
        n_checks++;
        if (c3[0] != 4 || c3[1] != 4 || c3[2] != 4) begin
            n_fail++;
            $display("FAIL range_ignore: pulses %0d %0d %0d expected 4 4 4", c3[0], c3[1], c3[2]);
        end
    endtask

    task automatic test_back_to_back();
        apply_pulse();
        repeat (5) tick();
        apply_pulse();
        for (int k = 1; k <= LOCK; k++) begin
            tick();
            n_checks++;
            if (locked !== 1'(k == LOCK)) begin
                n_fail++;
                $display("FAIL restart_lock edge %0d: locked=%b expected %b", k, locked, k == LOCK);
            end
        end
        for (int r = 1; r <= 8; r++) begin
            tick();
            n_checks++;
            if (ce !== exp_vec(r)) begin
                n_fail++;
                $display("FAIL restart_ce run %0d: ce=%b expected %b", r, ce, exp_vec(r));
            end
        end
    endtask

    task automatic test_async_reset();
        int w;
        w = 0;
        while (ce[0] !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        n_checks++;
        if (ce[0] !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: ce0=%b locked=%b expected 1 1", ce[0], locked);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({locked, ce, clk_out} !== 9'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %b expected 000000000", {locked, ce, clk_out});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) cur_inc[c] = DEF[c*32 +: 32];
        repeat (LOCK) tick();
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_relock: locked=%b expected 1", locked);
        end
        for (int r = 1; r <= 16; r++) begin
            tick();
            n_checks++;
            if (ce !== exp_vec(r)) begin
                n_fail++;
                $display("FAIL areset_defaults run %0d: ce=%b expected %b", r, ce, exp_vec(r));
            end
        end
    endtask

    initial begin
        test_reset();
        test_long_run();
        test_write_then_apply();
        test_same_edge();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
